// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the FP32 adder scheduler.
// The state encoding is shared so that the bench and the RTL use the same names.
package fp_sched_pkg;

   localparam int FP32_W = 32;

   localparam logic [FP32_W-1:0] FP_ONE = 32'h3F80_0000;
   localparam logic [FP32_W-1:0] FP_TWO = 32'h4000_0000;

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      SEND_A,
      SEND_B,
      WAIT_Z,
      RESP
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1 (mod N_REQ)
// and returns the first requesting index as both a one-hot vector and a binary index.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  last_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [ID_W-1:0]  grant_idx_o,
   output logic             valid_o
);

   logic [ID_W-1:0]  cand_idx [N_REQ];
   logic [N_REQ-1:0] cand_req;

   // Slot gi holds the requester that is gi+1 positions after the last winner.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = ID_W'((int'(last_i) + gi + 1) % N_REQ);
      assign cand_req[gi] = req_i[cand_idx[gi]];
   end

   always_comb begin
      valid_o     = 1'b0;
      grant_idx_o = '0;
      grant_o     = '0;
      // Walk from the lowest-priority slot down so the nearest requester wins.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (cand_req[i]) begin
            valid_o     = 1'b1;
            grant_idx_o = cand_idx[i];
         end
      end
      if (valid_o) begin
         grant_o[grant_idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/fp_adder_scheduler.sv
// Shares a single FP32 adder between N_REQ requesters: round-robin pick, push a then b,
// collect z, hand z back to the winner, then re-arbitrate. All outputs are registered.
module fp_adder_scheduler
   import fp_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_stb,
   input  logic [N_REQ*FP32_W-1:0]   req_a,
   input  logic [N_REQ*FP32_W-1:0]   req_b,
   output logic [N_REQ-1:0]          req_ack,
   output logic [N_REQ-1:0]          resp_stb,
   output logic [FP32_W-1:0]         resp_z,
   output logic [ID_W-1:0]           resp_id,
   input  logic [N_REQ-1:0]          resp_ack,
   output logic [FP32_W-1:0]         add_a,
   output logic                      add_a_stb,
   input  logic                      add_a_ack,
   output logic [FP32_W-1:0]         add_b,
   output logic                      add_b_stb,
   input  logic                      add_b_ack,
   input  logic [FP32_W-1:0]         add_z,
   input  logic                      add_z_stb,
   output logic                      add_z_ack,
   output logic                      busy,
   output logic [CNT_W-1:0]          op_count
);

   state_t              state_q, state_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   logic [ID_W-1:0]     last_q, last_d;
   logic [N_REQ-1:0]    req_ack_q, req_ack_d;
   logic [N_REQ-1:0]    resp_stb_q, resp_stb_d;
   logic [FP32_W-1:0]   resp_z_q, resp_z_d;
   logic [ID_W-1:0]     resp_id_q, resp_id_d;
   logic [FP32_W-1:0]   add_a_q, add_a_d;
   logic [FP32_W-1:0]   add_b_q, add_b_d;
   logic                add_a_stb_q, add_a_stb_d;
   logic                add_b_stb_q, add_b_stb_d;
   logic                add_z_ack_q, add_z_ack_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    op_count_q, op_count_d;

   logic [FP32_W-1:0]   req_a_arr [N_REQ];
   logic [FP32_W-1:0]   req_b_arr [N_REQ];
   logic [N_REQ-1:0]    arb_grant;
   logic [ID_W-1:0]     arb_idx;
   logic                arb_valid;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign req_a_arr[gi] = req_a[gi*FP32_W +: FP32_W];
      assign req_b_arr[gi] = req_b[gi*FP32_W +: FP32_W];
   end

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req_i       (req_stb),
      .last_i      (last_q),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx),
      .valid_o     (arb_valid)
   );

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      req_ack_d   = '0;
      resp_stb_d  = resp_stb_q;
      resp_z_d    = resp_z_q;
      resp_id_d   = resp_id_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      add_a_stb_d = add_a_stb_q;
      add_b_stb_d = add_b_stb_q;
      add_z_ack_d = add_z_ack_q;
      op_count_d  = op_count_q;

      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               grant_d   = arb_idx;
               req_ack_d = arb_grant;
               state_d   = ACCEPT;
            end
         end
         ACCEPT: begin
            // req_ack is high this cycle, so the operands transfer on the coming edge.
            add_a_d     = req_a_arr[grant_q];
            add_b_d     = req_b_arr[grant_q];
            last_d      = grant_q;
            add_a_stb_d = 1'b1;
            state_d     = SEND_A;
         end
         SEND_A: begin
            if (add_a_stb_q && add_a_ack) begin
               add_a_stb_d = 1'b0;
               add_b_stb_d = 1'b1;
               state_d     = SEND_B;
            end
         end
         SEND_B: begin
            if (add_b_stb_q && add_b_ack) begin
               add_b_stb_d = 1'b0;
               add_z_ack_d = 1'b1;
               state_d     = WAIT_Z;
            end
         end
         WAIT_Z: begin
            if (add_z_stb && add_z_ack_q) begin
               add_z_ack_d         = 1'b0;
               resp_z_d            = add_z;
               resp_id_d           = grant_q;
               resp_stb_d          = '0;
               resp_stb_d[grant_q] = 1'b1;
               state_d             = RESP;
            end
         end
         RESP: begin
            if (resp_stb_q[grant_q] && resp_ack[grant_q]) begin
               resp_stb_d = '0;
               op_count_d = op_count_q + CNT_W'(1);
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         last_q      <= ID_W'(N_REQ - 1);
         req_ack_q   <= '0;
         resp_stb_q  <= '0;
         resp_z_q    <= '0;
         resp_id_q   <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_a_stb_q <= 1'b0;
         add_b_stb_q <= 1'b0;
         add_z_ack_q <= 1'b0;
         busy_q      <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         req_ack_q   <= req_ack_d;
         resp_stb_q  <= resp_stb_d;
         resp_z_q    <= resp_z_d;
         resp_id_q   <= resp_id_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_a_stb_q <= add_a_stb_d;
         add_b_stb_q <= add_b_stb_d;
         add_z_ack_q <= add_z_ack_d;
         busy_q      <= busy_d;
         op_count_q  <= op_count_d;
      end
   end

   assign req_ack   = req_ack_q;
   assign resp_stb  = resp_stb_q;
   assign resp_z    = resp_z_q;
   assign resp_id   = resp_id_q;
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_a_stb = add_a_stb_q;
   assign add_b_stb = add_b_stb_q;
   assign add_z_ack = add_z_ack_q;
   assign busy      = busy_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_fp_adder_scheduler.sv
// Directed bench for fp_adder_scheduler: a small adder model answers the adder channels
// from a table of hand-computed FP32 sums; requester side is driven from one initial block.
module tb_fp_adder_scheduler;
   import fp_sched_pkg::*;

   localparam int N = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_stb;
   logic [N*32-1:0]   req_a;
   logic [N*32-1:0]   req_b;
   logic [N-1:0]      req_ack;
   logic [N-1:0]      resp_stb;
   logic [31:0]       resp_z;
   logic [1:0]        resp_id;
   logic [N-1:0]      resp_ack;
   logic [31:0]       add_a;
   logic              add_a_stb;
   logic              add_a_ack = 1'b0;
   logic [31:0]       add_b;
   logic              add_b_stb;
   logic              add_b_ack = 1'b0;
   logic [31:0]       add_z = '0;
   logic              add_z_stb = 1'b0;
   logic              add_z_ack;
   logic              busy;
   logic [15:0]       op_count;

   int tests_run    = 0;
   int tests_failed = 0;
   int exp_ops      = 0;
   int a_wait       = 0;
   int z_wait       = 0;
   int m_st         = 0;
   int m_cnt        = 0;
   logic [31:0] cap_a = '0;
   logic [31:0] cap_b = '0;

   fp_adder_scheduler #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_stb   (req_stb),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ack   (req_ack),
      .resp_stb  (resp_stb),
      .resp_z    (resp_z),
      .resp_id   (resp_id),
      .resp_ack  (resp_ack),
      .add_a     (add_a),
      .add_a_stb (add_a_stb),
      .add_a_ack (add_a_ack),
      .add_b     (add_b),
      .add_b_stb (add_b_stb),
      .add_b_ack (add_b_ack),
      .add_z     (add_z),
      .add_z_stb (add_z_stb),
      .add_z_ack (add_z_ack),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   // Hand-computed FP32 sums for every operand pair the bench uses.
   function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {FP_ONE, FP_TWO}, {FP_TWO, FP_ONE}: return 32'h4040_0000;  // 1+2=3
         {FP_ONE, FP_ONE}:                   return 32'h4000_0000;  // 1+1=2
         {FP_TWO, FP_TWO}:                   return 32'h4080_0000;  // 2+2=4
         {FP_TWO, 32'h4080_0000}:            return 32'h40C0_0000;  // 2+4=6
         {32'h3F00_0000, 32'h3E80_0000}:     return 32'h3F40_0000;  // 0.5+0.25=0.75
         default:                            return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic logic [3:0] onehot(input int id);
      onehot     = '0;
      onehot[id] = 1'b1;
   endfunction

   // Adder model: acts just after each rising edge, shares the scheduler reset.
   always begin
      @(posedge clk);
      #1;
      if (rst) begin
         m_st = 0; m_cnt = 0;
         add_a_ack = 1'b0; add_b_ack = 1'b0; add_z_stb = 1'b0; add_z = '0;
      end else begin
         case (m_st)
            0: if (add_a_stb) begin
                  if (m_cnt >= a_wait) begin
                     cap_a = add_a; add_a_ack = 1'b1; m_st = 1;
                  end else m_cnt++;
               end
            1: begin add_a_ack = 1'b0; m_st = 2; end
            2: if (add_b_stb) begin cap_b = add_b; add_b_ack = 1'b1; m_st = 3; end
            3: begin add_b_ack = 1'b0; m_cnt = 0; m_st = 4; end
            4: if (m_cnt >= z_wait) begin
                  add_z = fp_sum(cap_a, cap_b); add_z_stb = 1'b1; m_st = 5;
               end else m_cnt++;
            5: if (!add_z_ack) begin add_z_stb = 1'b0; m_cnt = 0; m_st = 0; end
            default: m_st = 0;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req_stb = '0; resp_ack = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_ops = 0;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic wait_grant(input int id, input bit drop, input string tag);
      int n = 0;
      while (req_ack == '0 && n < 60) begin @(negedge clk); n++; end
      check({tag, "_req_ack"}, 32'(req_ack), 32'(onehot(id)));
      @(negedge clk);
      check({tag, "_ack_pulse"}, 32'(req_ack), 32'h0);
      if (drop) req_stb[id] = 1'b0;
   endtask

   task automatic wait_resp(input int id, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] ez, input string tag);
      int n = 0;
      while (resp_stb == '0 && n < 200) begin @(negedge clk); n++; end
      check({tag, "_resp_stb"}, 32'(resp_stb), 32'(onehot(id)));
      check({tag, "_resp_id"}, 32'(resp_id), 32'(id));
      check({tag, "_resp_z"}, resp_z, ez);
      check({tag, "_adder_a"}, cap_a, ea);
      check({tag, "_adder_b"}, cap_b, eb);
   endtask

   task automatic ack_resp(input int id, input string tag);
      resp_ack = onehot(id);
      @(negedge clk);
      resp_ack = '0;
      exp_ops++;
      check({tag, "_op_count"}, 32'(op_count), 32'(exp_ops));
      check({tag, "_resp_drop"}, 32'(resp_stb), 32'h0);
      $display("[TB] op %s id=%0d z=%h count=%0d", tag, id, resp_z, op_count);
   endtask

   task automatic serve(input int id, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] ez, input bit drop, input string tag);
      wait_grant(id, drop, tag);
      wait_resp(id, ea, eb, ez, tag);
      ack_resp(id, tag);
   endtask

   initial begin
      rst = 1'b1; req_stb = '0; req_a = '0; req_b = '0; resp_ack = '0;
      do_reset();

      // Reset values.
      check("rst_req_ack",   32'(req_ack),   32'h0);
      check("rst_resp_stb",  32'(resp_stb),  32'h0);
      check("rst_add_a_stb", 32'(add_a_stb), 32'h0);
      check("rst_add_b_stb", 32'(add_b_stb), 32'h0);
      check("rst_add_z_ack", 32'(add_z_ack), 32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      check("rst_op_count",  32'(op_count),  32'h0);
      check("rst_resp_z",    resp_z,         32'h0);
      check("rst_resp_id",   32'(resp_id),   32'h0);
      check("rst_add_a",     add_a,          32'h0);

      // 1: single op 1.0 + 2.0.
      set_req(0, FP_ONE, FP_TWO);
      req_stb[0] = 1'b1;
      serve(0, FP_ONE, FP_TWO, 32'h4040_0000, 1'b1, "t1");

      // 2: all four held high -> 0,1,2,3,0.
      do_reset();
      set_req(0, FP_ONE, FP_ONE);
      set_req(1, FP_ONE, FP_TWO);
      set_req(2, FP_TWO, FP_TWO);
      set_req(3, FP_TWO, 32'h4080_0000);
      req_stb = 4'hF;
      serve(0, FP_ONE, FP_ONE, 32'h4000_0000, 1'b0, "t2_r0");
      serve(1, FP_ONE, FP_TWO, 32'h4040_0000, 1'b0, "t2_r1");
      serve(2, FP_TWO, FP_TWO, 32'h4080_0000, 1'b0, "t2_r2");
      serve(3, FP_TWO, 32'h4080_0000, 32'h40C0_0000, 1'b0, "t2_r3");
      serve(0, FP_ONE, FP_ONE, 32'h4000_0000, 1'b0, "t2_r0b");

      // 3: pointer wrap from last=3 with requesters 0 and 2 -> 0 then 2.
      do_reset();
      req_stb = 4'b0101;
      serve(0, FP_ONE, FP_ONE, 32'h4000_0000, 1'b0, "t3_r0");
      serve(2, FP_TWO, FP_TWO, 32'h4080_0000, 1'b0, "t3_r2");

      // 4: result held while resp_ack[g] stays low; other ack bits ignored.
      do_reset();
      set_req(1, 32'h3F00_0000, 32'h3E80_0000);
      req_stb = 4'b0010;
      wait_grant(1, 1'b1, "t4");
      req_stb[3] = 1'b1;
      wait_resp(1, 32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000, "t4");
      resp_ack = 4'b1101;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("t4_hold_resp_stb",  32'(resp_stb),  32'h2);
         check("t4_hold_resp_z",    resp_z,         32'h3F40_0000);
         check("t4_hold_req_ack",   32'(req_ack),   32'h0);
         check("t4_hold_add_a_stb", 32'(add_a_stb), 32'h0);
         check("t4_hold_busy",      32'(busy),      32'h1);
      end
      resp_ack = '0;
      ack_resp(1, "t4");
      serve(3, FP_TWO, 32'h4080_0000, 32'h40C0_0000, 1'b1, "t4_r3");

      // 5: adder stalls add_a_ack for 5 cycles.
      do_reset();
      a_wait = 5;
      set_req(2, FP_ONE, FP_ONE);
      req_stb = 4'b0100;
      wait_grant(2, 1'b1, "t5");
      for (int c = 0; c < 5; c++) begin
         check("t5_stall_a_stb", 32'(add_a_stb), 32'h1);
         check("t5_stall_a",     add_a,          FP_ONE);
         check("t5_stall_b_stb", 32'(add_b_stb), 32'h0);
         @(negedge clk);
      end
      begin
         int n = 0;
         while (!add_b_stb && n < 20) begin @(negedge clk); n++; end
      end
      check("t5_send_b_stb",  32'(add_b_stb), 32'h1);
      check("t5_a_stb_drop",  32'(add_a_stb), 32'h0);
      wait_resp(2, FP_ONE, FP_ONE, 32'h4000_0000, "t5");
      ack_resp(2, "t5");
      a_wait = 0;

      // 6: reset pulse during WAIT_Z, then a fresh op.
      do_reset();
      z_wait = 1000;
      set_req(1, FP_TWO, FP_TWO);
      req_stb = 4'b0010;
      wait_grant(1, 1'b1, "t6");
      begin
         int n = 0;
         while (!add_z_ack && n < 40) begin @(negedge clk); n++; end
      end
      check("t6_in_wait_z", 32'(add_z_ack), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_ops = 0;
      check("t6_req_ack",   32'(req_ack),   32'h0);
      check("t6_resp_stb",  32'(resp_stb),  32'h0);
      check("t6_add_a_stb", 32'(add_a_stb), 32'h0);
      check("t6_add_b_stb", 32'(add_b_stb), 32'h0);
      check("t6_add_z_ack", 32'(add_z_ack), 32'h0);
      check("t6_op_count",  32'(op_count),  32'h0);
      check("t6_busy",      32'(busy),      32'h0);
      z_wait = 0;
      set_req(2, FP_ONE, FP_ONE);
      req_stb = 4'b0100;
      serve(2, FP_ONE, FP_ONE, 32'h4000_0000, 1'b1, "t6_fresh");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
